// File: rtl/wb_pkg.sv
// Shared Wishbone B4 encodings and the slave FSM state type for the
// wb_mem_slave block and its burst address generator.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    BURST = 2'd3
  } state_t;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Combinational next-word-index calculator for Wishbone incrementing bursts:
// linear mode adds one, wrap modes roll over inside a 4/8/16-word block.
module wb_burst_addr_gen
  import wb_pkg::*;
#(
  parameter int IDX_W = 36
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic [1:0]       bte_i,
  output logic [IDX_W-1:0] next_o
);

  always_comb begin
    next_o = idx_i + IDX_W'(1);
    case (bte_i)
      BTE_WRAP4:  next_o = {idx_i[IDX_W-1:2], idx_i[1:0] + 2'd1};
      BTE_WRAP8:  next_o = {idx_i[IDX_W-1:3], idx_i[2:0] + 3'd1};
      BTE_WRAP16: next_o = {idx_i[IDX_W-1:4], idx_i[3:0] + 4'd1};
      default:    next_o = idx_i + IDX_W'(1);
    endcase
  end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone B4 registered-feedback memory slave with classic and incrementing
// burst support, byte-lane writes, programmable first-beat latency and range errors.
module wb_mem_slave
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 39,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 4096,
  parameter int READ_DELAY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic [2:0]              wb_cti_i,
  input  logic [1:0]              wb_bte_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o
);

  localparam int LANES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(LANES);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int MEM_AW = $clog2(MEM_DEPTH);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             we_q, we_d;
  logic [1:0]       bte_q, bte_d;
  logic [3:0]       cnt_q, cnt_d;

  logic [IDX_W-1:0] adr_idx;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_en;
  logic             rd_fire;
  logic             beat;
  logic             in_range;
  logic             wr_en;
  logic             unused_adr_bits;

  assign adr_idx         = wb_adr_i[ADDR_WIDTH-1:OFF_W];
  assign unused_adr_bits = ^wb_adr_i[OFF_W-1:0];

  wb_burst_addr_gen #(
    .IDX_W (IDX_W)
  ) u_addr_gen (
    .idx_i  (idx_q),
    .bte_i  (bte_q),
    .next_o (next_idx)
  );

  // A beat terminates in any cycle where the slave is responding and the
  // master is still presenting a strobe; range decides ack versus err.
  assign in_range = (idx_q < IDX_W'(MEM_DEPTH));
  assign beat     = ((state_q == RESP) || (state_q == BURST)) && wb_cyc_i && wb_stb_i;
  assign wb_ack_o = beat && in_range;
  assign wb_err_o = beat && !in_range;
  assign wb_rty_o = 1'b0;
  assign wr_en    = wb_ack_o && we_q && !rst;
  assign rd_fire  = rd_en && (rd_idx < IDX_W'(MEM_DEPTH));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    bte_d   = bte_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          idx_d  = adr_idx;
          we_d   = wb_we_i;
          bte_d  = wb_bte_i;
          rd_idx = adr_idx;
          if (READ_DELAY == 0) begin
            state_d = RESP;
            rd_en   = !wb_we_i;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(READ_DELAY);
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
          rd_en   = !we_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP, BURST: begin
        // Prefetch the following word so the next burst beat acks with no bubble.
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (wb_stb_i) begin
          if (wb_cti_i == CTI_INCR) begin
            state_d = BURST;
            idx_d   = next_idx;
            rd_idx  = next_idx;
            rd_en   = !we_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      bte_q   <= BTE_LINEAR;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      bte_q   <= bte_d;
      cnt_q   <= cnt_d;
    end
  end

  // One byte-wide storage array per lane keeps lane enables trivially mappable.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [MEM_DEPTH];
      logic [7:0] dat_q;

      always_ff @(posedge clk) begin
        if (wr_en && wb_sel_i[gi]) begin
          mem[idx_q[MEM_AW-1:0]] <= wb_dat_i[gi*8 +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          dat_q <= 8'd0;
        end else if (rd_fire) begin
          dat_q <= mem[rd_idx[MEM_AW-1:0]];
        end
      end

      assign wb_dat_o[gi*8 +: 8] = dat_q;
    end
  endgenerate

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed self-checking bench for wb_mem_slave: classic cycles, lane writes,
// wrap and linear bursts with wait states, range errors, abort and reset.
module tb_wb_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [38:0] adr;
  logic [63:0] wdat;
  logic [7:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;
  logic [63:0] rdat;

  int n_checks = 0;
  int n_err    = 0;

  wb_mem_slave #(
    .ADDR_WIDTH (39),
    .DATA_WIDTH (64),
    .MEM_DEPTH  (4096),
    .READ_DELAY (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_sel_i (sel),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty),
    .wb_dat_o (rdat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Classic single cycle: returns edges-to-termination, the termination flags,
  // the read data, and whether any termination appeared one cycle later.
  task automatic classic(input logic w, input logic [38:0] a, input logic [63:0] d,
                         input logic [7:0] s, output int lat, output logic c_ack,
                         output logic c_err, output logic c_rty, output logic [63:0] c_dat,
                         output logic c_after);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    cti = 3'b000; bte = 2'b00;
    #1;
    lat = 0;
    while (!(ack || err) && lat < 16) begin
      tick();
      lat++;
    end
    c_ack = ack; c_err = err; c_rty = rty; c_dat = rdat;
    tick();
    c_after = ack | err;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    $display("classic %s adr=%h lat=%0d ack=%b err=%b dat=%h",
             w ? "wr" : "rd", a, lat, c_ack, c_err, c_dat);
  endtask

  task automatic wr(input logic [38:0] a, input logic [63:0] d);
    int l; logic k, e, r, f; logic [63:0] q;
    classic(1'b1, a, d, 8'hFF, l, k, e, r, q, f);
  endtask

  // Incrementing read burst of n beats; optional stb-low gap before beat gap_at.
  task automatic burst_rd(input string tag, input logic [38:0] a, input logic [1:0] b,
                          input int n, input int gap_at, input int gap_len,
                          input logic [7:0][63:0] expv);
    int t;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; cti = 3'b010; bte = b; sel = 8'hFF;
    #1;
    t = 0;
    while (!ack && t < 16) begin
      tick();
      t++;
    end
    chk({tag, " first ack latency"}, 64'(t), 64'd2);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        tick();
        adr = 39'h0;
        if (i == gap_at) begin
          stb = 1'b0;
          for (int g = 0; g < gap_len; g++) begin
            #1;
            chk({tag, " gap ack"}, 64'(ack | err), 64'd0);
            tick();
          end
          stb = 1'b1;
        end
        if (i == n - 1) cti = 3'b111;
        #1;
      end
      chk({tag, " beat ack"}, 64'(ack), 64'd1);
      chk({tag, " beat data"}, rdat, expv[i]);
      $display("burst %s beat %0d ack=%b dat=%h", tag, i, ack, rdat);
    end
    tick();
    chk({tag, " idle after eob"}, 64'(ack | err), 64'd0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    tick();
  endtask

  initial begin
    int          lat;
    int          t;
    logic        c_ack, c_err, c_rty, c_after;
    logic [63:0] c_dat;
    logic [7:0][63:0] ev;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    sel = '0; cti = '0; bte = '0;
    repeat (3) tick();
    chk("reset ack", 64'(ack), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset rty", 64'(rty), 64'd0);
    chk("reset dat", rdat, 64'd0);
    rst = 1'b0;
    tick();

    // Classic write then read back.
    classic(1'b1, 39'h40, 64'h1122334455667788, 8'hFF, lat, c_ack, c_err, c_rty, c_dat, c_after);
    chk("wr40 latency", 64'(lat), 64'd2);
    chk("wr40 ack", 64'(c_ack), 64'd1);
    chk("wr40 err", 64'(c_err), 64'd0);
    chk("wr40 single pulse", 64'(c_after), 64'd0);
    classic(1'b0, 39'h40, 64'h0, 8'hFF, lat, c_ack, c_err, c_rty, c_dat, c_after);
    chk("rd40 latency", 64'(lat), 64'd2);
    chk("rd40 data", c_dat, 64'h1122334455667788);

    // Low four byte lanes only.
    classic(1'b1, 39'h40, 64'hAAAAAAAABBBBBBBB, 8'h0F, lat, c_ack, c_err, c_rty, c_dat, c_after);
    classic(1'b0, 39'h40, 64'h0, 8'hFF, lat, c_ack, c_err, c_rty, c_dat, c_after);
    chk("rd40 lane data", c_dat, 64'h11223344BBBBBBBB);

    // Preload: word 0 marker, words 4..7 and 20..24 hold their index, 32..34 a pattern.
    wr(39'h0, 64'hDEADBEEFCAFEF00D);
    for (int w = 4; w < 8; w++) wr(39'(w * 8), 64'(w));
    for (int w = 20; w < 25; w++) wr(39'(w * 8), 64'(w));
    for (int w = 32; w < 35; w++) wr(39'(w * 8), 64'h5555555555555555);

    ev = '0;
    ev[0] = 64'd6; ev[1] = 64'd7; ev[2] = 64'd4; ev[3] = 64'd5;
    burst_rd("wrap4", 39'h30, 2'b01, 4, -1, 0, ev);

    ev = '0;
    ev[0] = 64'd20; ev[1] = 64'd21; ev[2] = 64'd22; ev[3] = 64'd23; ev[4] = 64'd24;
    burst_rd("linear", 39'hA0, 2'b00, 5, 2, 2, ev);

    // Word index 4096 is past the end of storage.
    classic(1'b0, 39'h8000, 64'h0, 8'hFF, lat, c_ack, c_err, c_rty, c_dat, c_after);
    chk("oor rd latency", 64'(lat), 64'd2);
    chk("oor rd err", 64'(c_err), 64'd1);
    chk("oor rd ack", 64'(c_ack), 64'd0);
    chk("oor rd rty", 64'(c_rty), 64'd0);
    chk("oor rd dat held", c_dat, 64'd24);
    classic(1'b1, 39'h8000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, lat, c_ack, c_err, c_rty, c_dat, c_after);
    chk("oor wr err", 64'(c_err), 64'd1);
    chk("oor wr ack", 64'(c_ack), 64'd0);
    classic(1'b0, 39'h0, 64'h0, 8'hFF, lat, c_ack, c_err, c_rty, c_dat, c_after);
    chk("word0 unchanged", c_dat, 64'hDEADBEEFCAFEF00D);

    // Eight-beat write burst abandoned after two beats.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 39'h100; wdat = 64'h0A0A0A0A0A0A0A0A;
    sel = 8'hFF; cti = 3'b010; bte = 2'b00;
    #1;
    t = 0;
    while (!ack && t < 16) begin
      tick();
      t++;
    end
    chk("abort first ack latency", 64'(t), 64'd2);
    tick();
    wdat = 64'h0B0B0B0B0B0B0B0B;
    #1;
    chk("abort beat1 ack", 64'(ack), 64'd1);
    tick();
    cyc = 1'b0; stb = 1'b0;
    #1;
    chk("abort ack after cyc drop", 64'(ack | err), 64'd0);
    tick();
    $display("write burst aborted after 2 beats");

    // New cycle interrupted by reset.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 39'h100; cti = 3'b000;
    tick();
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    tick();
    chk("midrst ack", 64'(ack), 64'd0);
    chk("midrst err", 64'(err), 64'd0);
    chk("midrst dat", rdat, 64'd0);
    rst = 1'b0;
    $display("reset pulsed mid-cycle");

    classic(1'b0, 39'h100, 64'h0, 8'hFF, lat, c_ack, c_err, c_rty, c_dat, c_after);
    chk("post-rst rd latency", 64'(lat), 64'd2);
    chk("post-rst rd ack", 64'(c_ack), 64'd1);
    chk("abort word32", c_dat, 64'h0A0A0A0A0A0A0A0A);
    classic(1'b0, 39'h108, 64'h0, 8'hFF, lat, c_ack, c_err, c_rty, c_dat, c_after);
    chk("abort word33", c_dat, 64'h0B0B0B0B0B0B0B0B);
    classic(1'b0, 39'h110, 64'h0, 8'hFF, lat, c_ack, c_err, c_rty, c_dat, c_after);
    chk("abort word34 untouched", c_dat, 64'h5555555555555555);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
